// File: rtl/memory_lsu_pkg.sv
// Shared opcodes, funct3 codes, FSM state encoding and fault-decode helpers
// for the RV32I load/store unit.
package memory_lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FIN
  } state_e;

  function automatic logic is_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    if (is_store) bad = (f3 > 3'd2);
    else          bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    return bad;
  endfunction

  // Width is encoded in funct3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/memory_lsu_align.sv
// Combinational lane logic: little-endian load extract with sign/zero extension,
// and sub-word store merge into a previously read RAM word.
module memory_lsu_align
  import memory_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    half_sel = rdata_i[{lane_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'h000000, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'h0000, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

  always_comb begin
    merge_data_o = rdata_i;
    case (funct3_i)
      F3_B:    merge_data_o[{lane_i, 3'b000} +: 8]    = store_data_i[7:0];
      F3_H:    merge_data_o[{lane_i[1], 4'b0000} +: 16] = store_data_i[15:0];
      default: merge_data_o = store_data_i;
    endcase
  end

endmodule

// File: rtl/memory_lsu.sv
// RV32I load/store unit driving a load-only RAM port A and a store port B;
// sub-word stores are done as read-modify-write since the RAM has no byte enables.
module memory_lsu
  import memory_lsu_pkg::*;
#(
  parameter int RAM_RD_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        i_START,
  input  logic [6:0]  i_OPCODE,
  input  logic [2:0]  i_FUNCT3,
  input  logic [31:0] i_ADDR,
  input  logic [31:0] i_STORE_DATA,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic [31:0] o_LOAD_DATA,
  output logic        o_MISALIGNED,
  output logic        o_ILLEGAL,
  output logic        o_A_RAM_CE,
  output logic        o_A_RAM_RD,
  output logic        o_A_RAM_WR,
  output logic [31:0] o_A_RAM_ADDR,
  input  logic [31:0] i_A_RAM_DATA_RD,
  output logic [31:0] o_A_RAM_DATA_WR,
  output logic        o_B_RAM_CE,
  output logic        o_B_RAM_RD,
  output logic        o_B_RAM_WR,
  output logic [31:0] o_B_RAM_ADDR,
  input  logic [31:0] i_B_RAM_DATA_RD,
  output logic [31:0] o_B_RAM_DATA_WR
);

  localparam logic [1:0] LAT_LAST = 2'(RAM_RD_LAT - 1);

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        is_store_q, fault_mis_q, fault_ill_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, sdata_q, wdata_q, load_q;
  logic        busy_q, done_q, mis_q, ill_q;
  logic        a_ce_q, a_rd_q, b_ce_q, b_rd_q, b_wr_q;

  logic        req_ok, req_store, req_ill, req_mis;
  logic [31:0] rdata, load_val, merge_val;

  assign req_ok    = i_START && ((i_OPCODE == OP_LOAD) || (i_OPCODE == OP_STORE));
  assign req_store = (i_OPCODE == OP_STORE);
  assign req_ill   = is_illegal(req_store, i_FUNCT3);
  assign req_mis   = !req_ill && is_misaligned(i_FUNCT3, i_ADDR[1:0]);

  assign rdata = is_store_q ? i_B_RAM_DATA_RD : i_A_RAM_DATA_RD;

  memory_lsu_align u_align (
    .funct3_i     (funct3_q),
    .lane_i       (addr_q[1:0]),
    .rdata_i      (rdata),
    .store_data_i (sdata_q),
    .load_data_o  (load_val),
    .merge_data_o (merge_val)
  );

  // Strobes and status flags default low each cycle so every pulse lasts one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      is_store_q  <= 1'b0;
      fault_mis_q <= 1'b0;
      fault_ill_q <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'h0;
      sdata_q     <= 32'h0;
      wdata_q     <= 32'h0;
      load_q      <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
      a_ce_q      <= 1'b0;
      a_rd_q      <= 1'b0;
      b_ce_q      <= 1'b0;
      b_rd_q      <= 1'b0;
      b_wr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      ill_q  <= 1'b0;
      a_ce_q <= 1'b0;
      a_rd_q <= 1'b0;
      b_ce_q <= 1'b0;
      b_rd_q <= 1'b0;
      b_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_ok) begin
            is_store_q  <= req_store;
            funct3_q    <= i_FUNCT3;
            addr_q      <= i_ADDR;
            sdata_q     <= i_STORE_DATA;
            fault_ill_q <= req_ill;
            fault_mis_q <= req_mis;
            if (req_ill || req_mis) begin
              state_q <= FIN;
            end else if (req_store && (i_FUNCT3 == F3_W)) begin
              state_q <= WR_REQ;
              busy_q  <= 1'b1;
              wdata_q <= i_STORE_DATA;
              b_ce_q  <= 1'b1;
              b_wr_q  <= 1'b1;
            end else begin
              state_q <= RD_REQ;
              busy_q  <= 1'b1;
              a_ce_q  <= !req_store;
              a_rd_q  <= !req_store;
              b_ce_q  <= req_store;
              b_rd_q  <= req_store;
            end
          end
        end
        RD_REQ: begin
          state_q <= RD_WAIT;
          cnt_q   <= 2'd0;
        end
        RD_WAIT: begin
          if (cnt_q == LAT_LAST) begin
            if (is_store_q) begin
              state_q <= WR_REQ;
              wdata_q <= merge_val;
              b_ce_q  <= 1'b1;
              b_wr_q  <= 1'b1;
            end else begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              load_q  <= load_val;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        WR_REQ: begin
          state_q <= FIN;
          busy_q  <= 1'b0;
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          mis_q   <= fault_mis_q;
          ill_q   <= fault_ill_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_BUSY          = busy_q;
  assign o_DONE          = done_q;
  assign o_LOAD_DATA     = load_q;
  assign o_MISALIGNED    = mis_q;
  assign o_ILLEGAL       = ill_q;
  assign o_A_RAM_CE      = a_ce_q;
  assign o_A_RAM_RD      = a_rd_q;
  assign o_A_RAM_WR      = 1'b0;
  assign o_A_RAM_ADDR    = {addr_q[31:2], 2'b00};
  assign o_A_RAM_DATA_WR = 32'h0;
  assign o_B_RAM_CE      = b_ce_q;
  assign o_B_RAM_RD      = b_rd_q;
  assign o_B_RAM_WR      = b_wr_q;
  assign o_B_RAM_ADDR    = {addr_q[31:2], 2'b00};
  assign o_B_RAM_DATA_WR = wdata_q;

endmodule
